stack_cpu_param: RTL
====================

Name: stack_cpu_param

Overview:
- Parametrised multicycle stack-machine controller, successor to the lab's 8-bit fixed-width processor.
- Fetches 4-bit opcodes plus optional one-word operands from a word-addressed RAM.
- Operates on an external stack through push/pop strobes.
- Adds over the previous generation: configurable data/address width, carry flag, HALT opcode, and a sticky fault state for stack overflow, stack underflow and illegal opcodes.

Parameters:
DATA_W, 8, width of RAM words, stack entries and ALU; must be >= ADDR_W and >= 4
ADDR_W, 8, width of program counter and RAM address

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
halt_n  in  1  run enable; low freezes the controller
mem_addr  out  ADDR_W  RAM address
mem_rdata  in  DATA_W  RAM read data, combinational from mem_addr
mem_wdata  out  DATA_W  RAM write data
mem_we  out  1  RAM write strobe, 1 = write
stk_rdata  in  DATA_W  current top of stack, combinational
stk_wdata  out  DATA_W  data to push
stk_push  out  1  push strobe, one cycle per push
stk_pop  out  1  pop strobe; top removed at the edge ending the strobe cycle
stk_full  in  1  stack full
stk_empty  in  1  stack empty
flags  out  3  {c, s, z}
halted  out  1  HALT opcode executed
fault  out  1  sticky fault
fault_code  out  2  fault cause: 0 none, 1 overflow, 2 underflow, 3 illegal opcode

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high on port `reset`.
- Reset values: pc=0, flags=0, halted=0, fault=0, fault_code=0, mem_addr=0, mem_we=0, stk_push=0, stk_pop=0, wdata outputs 0; state=FETCH.
- Reset mid-instruction aborts it; no strobe is issued on the reset cycle.
- Stalling: halt_n=0 holds state and all registers. mem_we, stk_push and stk_pop are forced to 0. Execution resumes in the same state when halt_n returns to 1.
- Opcode: mem_rdata[3:0]. Opcodes: 0 PUSHC imm, 1 PUSH addr, 2 POP addr, 3 JUMP, 4 JZ, 5 JS, 6 ADD, 7 SUB, 8 HALT. All others are illegal.
- pc increments by 1 per word fetched and wraps modulo 2^ADDR_W.
- States: FETCH, ARG, MREAD, PUSHW, POPW, JMP, ALU_A, ALU_B, ALU_W, HALTED, FAULT.
- FETCH: mem_addr=pc; latch opcode; pc+1.
  - Opcodes 0-2 -> ARG.
  - Opcode 3 -> JMP.
  - Opcode 4 -> JMP if z else FETCH; opcode 5 -> JMP if s else FETCH. The not-taken case costs 1 cycle total.
  - Opcodes 6/7 -> ALU_A; opcode 8 -> HALTED; illegal -> FAULT (code 3).
- ARG: mem_addr=pc; latch operand; pc+1. PUSHC -> PUSHW with data=operand; PUSH -> MREAD; POP -> POPW.
- MREAD: mem_addr=operand; latch data -> PUSHW.
- PUSHW: if stk_full -> FAULT (code 1), no push. Else stk_push=1, stk_wdata=data -> FETCH.
- POPW: if stk_empty -> FAULT (code 2). Else stk_pop=1, mem_we=1, mem_addr=operand[ADDR_W-1:0], mem_wdata=stk_rdata -> FETCH.
- JMP: empty -> FAULT (code 2). Else stk_pop=1; pc<=stk_rdata[ADDR_W-1:0] -> FETCH.
- ALU_A: empty check, then pop; a<=stk_rdata.
- ALU_B: empty check, then pop; b<=stk_rdata.
- ALU_W: push r. ADD: r=b+a; SUB: r=b-a (earlier-pushed minus top); both DATA_W bits, wrapping.
  - z=(r==0); s=r[DATA_W-1].
  - c = carry-out for ADD, borrow for SUB.
  - Flags update only in ALU_W. No full check is needed, since two entries were just popped.
- Cycle counts: PUSHC 3, PUSH 4, POP 3, JUMP/taken JZ/JS 2, ALU 4, HALT 1.
- HALTED and FAULT are absorbing until reset. All strobes are 0 in both states. fault_code is held.

Optional Feature:
- Macro STACK_CPU_JC_EN.
- Defined: opcode 9 = JC, which jumps (JMP state) if c=1 and otherwise returns to FETCH, exactly like JZ.
- Undefined: opcode 9 is illegal -> FAULT code 3. The c flag is still computed and output.

Test Plan:
- ALU sequence: PUSHC 5, PUSHC 3, SUB, POP 0x20 -> RAM[0x20]=2; flags z=0,s=0,c=0; 13 cycles.
- Carry/zero/sign: PUSHC 0xFF, PUSHC 0x01, ADD -> top=0x00, z=1, c=1, s=0. Then PUSHC 0x00, PUSHC 0x01, SUB -> top=0xFF, s=1, c=1.
- Jumps: PUSHC 0x10, JZ with z=0 -> no pop, pc=next instruction. Same sequence with z=1 -> pop, next fetch at 0x10.
- Faults: stk_empty=1 at ADD -> fault=1, code 2, no stk_pop issued. PUSHC with stk_full=1 -> code 1. Opcode 0xA -> code 3. All three hold until reset.
- Stall/reset: halt_n=0 for 5 cycles mid-PUSH -> state and pc frozen, no strobes, completes after release. reset=1 during ALU_B -> pc=0, no push.
- HALT, and JC with and without STACK_CPU_JC_EN:
  - HALT -> halted=1, mem_addr stable, no strobes for 20 cycles.
  - Opcode 9 with c=1 -> jump when the macro is defined; fault code 3 when it is not.

Source files
------------

// File: rtl/stack_cpu_param.sv
// Multicycle stack-machine controller: 4-bit opcodes, external stack, carry flag, sticky faults.
// Define STACK_CPU_JC_EN to enable opcode 9 (JC, jump on carry); otherwise opcode 9 is illegal.
module stack_cpu_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt_n,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] stk_rdata,
    output logic [DATA_W-1:0] stk_wdata,
    output logic              stk_push,
    output logic              stk_pop,
    input  logic              stk_full,
    input  logic              stk_empty,
    output logic [2:0]        flags,
    output logic              halted,
    output logic              fault,
    output logic [1:0]        fault_code
);

    typedef enum logic [3:0] {
        S_FETCH, S_ARG, S_MREAD, S_PUSHW, S_POPW, S_JMP,
        S_ALU_A, S_ALU_B, S_ALU_W, S_HALTED, S_FAULT
    } state_t;

    localparam logic [3:0] OP_PUSHC = 4'd0;
    localparam logic [3:0] OP_PUSH  = 4'd1;
    localparam logic [3:0] OP_POP   = 4'd2;
    localparam logic [3:0] OP_JUMP  = 4'd3;
    localparam logic [3:0] OP_JZ    = 4'd4;
    localparam logic [3:0] OP_JS    = 4'd5;
    localparam logic [3:0] OP_ADD   = 4'd6;
    localparam logic [3:0] OP_SUB   = 4'd7;
    localparam logic [3:0] OP_HALT  = 4'd8;
`ifdef STACK_CPU_JC_EN
    localparam logic [3:0] OP_JC    = 4'd9;
`endif
    localparam logic [ADDR_W-1:0] PC_ONE = 1;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   pc, pc_n;
    logic [3:0]          op, op_n;
    logic [DATA_W-1:0]   opnd, opnd_n, data_r, data_n, a_r, a_n, b_r, b_n;
    logic [2:0]          flags_r, flags_n;
    logic [1:0]          fcode, fcode_n;
    logic                push_c, pop_c, we_c;
    logic [DATA_W:0]     sum;

    // Top bit of sum is carry-out for ADD and borrow for SUB.
    always_comb begin
        if (op == OP_SUB) sum = {1'b0, b_r} - {1'b0, a_r};
        else              sum = {1'b0, b_r} + {1'b0, a_r};
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        op_n      = op;
        opnd_n    = opnd;
        data_n    = data_r;
        a_n       = a_r;
        b_n       = b_r;
        flags_n   = flags_r;
        fcode_n   = fcode;
        mem_addr  = pc;
        mem_wdata = '0;
        stk_wdata = '0;
        push_c    = 1'b0;
        pop_c     = 1'b0;
        we_c      = 1'b0;
        case (state)
            S_FETCH: begin
                op_n = mem_rdata[3:0];
                pc_n = pc + PC_ONE;
                case (mem_rdata[3:0])
                    OP_PUSHC, OP_PUSH, OP_POP: state_n = S_ARG;
                    OP_JUMP:                   state_n = S_JMP;
                    OP_JZ:                     state_n = flags_r[0] ? S_JMP : S_FETCH;
                    OP_JS:                     state_n = flags_r[1] ? S_JMP : S_FETCH;
                    OP_ADD, OP_SUB:            state_n = S_ALU_A;
                    OP_HALT:                   state_n = S_HALTED;
`ifdef STACK_CPU_JC_EN
                    OP_JC:                     state_n = flags_r[2] ? S_JMP : S_FETCH;
`endif
                    default: begin
                        state_n = S_FAULT;
                        fcode_n = 2'd3;
                    end
                endcase
            end
            S_ARG: begin
                opnd_n = mem_rdata;
                data_n = mem_rdata;
                pc_n   = pc + PC_ONE;
                if (op == OP_PUSHC)     state_n = S_PUSHW;
                else if (op == OP_PUSH) state_n = S_MREAD;
                else                    state_n = S_POPW;
            end
            S_MREAD: begin
                mem_addr = opnd[ADDR_W-1:0];
                data_n   = mem_rdata;
                state_n  = S_PUSHW;
            end
            S_PUSHW: begin
                if (stk_full) begin
                    state_n = S_FAULT;
                    fcode_n = 2'd1;
                end else begin
                    push_c    = 1'b1;
                    stk_wdata = data_r;
                    state_n   = S_FETCH;
                end
            end
            S_POPW: begin
                mem_addr = opnd[ADDR_W-1:0];
                if (stk_empty) begin
                    state_n = S_FAULT;
                    fcode_n = 2'd2;
                end else begin
                    pop_c     = 1'b1;
                    we_c      = 1'b1;
                    mem_wdata = stk_rdata;
                    state_n   = S_FETCH;
                end
            end
            S_JMP, S_ALU_A, S_ALU_B: begin
                if (stk_empty) begin
                    state_n = S_FAULT;
                    fcode_n = 2'd2;
                end else begin
                    pop_c = 1'b1;
                    case (state)
                        S_JMP:   begin pc_n = stk_rdata[ADDR_W-1:0]; state_n = S_FETCH; end
                        S_ALU_A: begin a_n = stk_rdata; state_n = S_ALU_B; end
                        default: begin b_n = stk_rdata; state_n = S_ALU_W; end
                    endcase
                end
            end
            S_ALU_W: begin
                push_c    = 1'b1;
                stk_wdata = sum[DATA_W-1:0];
                flags_n   = {sum[DATA_W], sum[DATA_W-1], sum[DATA_W-1:0] == '0};
                state_n   = S_FETCH;
            end
            default: state_n = state;
        endcase
    end

    // Strobes are suppressed while stalled and on the reset cycle.
    assign stk_push   = push_c & halt_n & ~reset;
    assign stk_pop    = pop_c  & halt_n & ~reset;
    assign mem_we     = we_c   & halt_n & ~reset;
    assign flags      = flags_r;
    assign halted     = (state == S_HALTED);
    assign fault      = (state == S_FAULT);
    assign fault_code = fcode;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            pc      <= '0;
            op      <= '0;
            opnd    <= '0;
            data_r  <= '0;
            a_r     <= '0;
            b_r     <= '0;
            flags_r <= '0;
            fcode   <= '0;
        end else if (halt_n) begin
            state   <= state_n;
            pc      <= pc_n;
            op      <= op_n;
            opnd    <= opnd_n;
            data_r  <= data_n;
            a_r     <= a_n;
            b_r     <= b_n;
            flags_r <= flags_n;
            fcode   <= fcode_n;
        end
    end

endmodule
